// File: rtl/core_pkg.sv
// Shared definitions for the memory-access pipeline stage.
//  - Opcode and funct3 constants used by the decode in memory_access.
//  - mem_state_t : stage FSM states.
//  - wb_elements : writeback record presented to the register-file port.
package core_pkg;

  localparam int CORE_XLEN   = 32;
  localparam int CORE_RIDX_W = 5;

  localparam logic [7:0] OP_ALU    = 8'h33;
  localparam logic [7:0] OP_ALUI   = 8'h13;
  localparam logic [7:0] OP_LOAD   = 8'h03;
  localparam logic [7:0] OP_STORE  = 8'h23;
  localparam logic [7:0] OP_JAL    = 8'h6f;
  localparam logic [7:0] OP_BRANCH = 8'h63;
  localparam logic [2:0] F3_WORD   = 3'h2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    HOLD = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic                   we;
    logic [CORE_RIDX_W-1:0] rd;
    logic [CORE_XLEN-1:0]   rd_d;
    logic [CORE_XLEN-1:0]   pc;
  } wb_elements;

  // Register-file write enable for an incoming record. Only word-wide loads
  // count as loads; a load opcode with any other funct3 is an unknown op and
  // does not write. Writes to x0 are suppressed.
  function automatic logic wb_write_en(input logic [7:0] op,
                                       input logic [2:0] funct3,
                                       input logic [CORE_RIDX_W-1:0] rd);
    logic we;
    we = (op == OP_ALU) || (op == OP_ALUI) || (op == OP_JAL) ||
         ((op == OP_LOAD) && (funct3 == F3_WORD));
    return we && (rd != '0);
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Ack watchdog for the memory-access stage (built only with MEM_TIMEOUT_EN).
//  clock, reset_n : clock, asynchronous active-low reset
//  run            : high while a memory request is outstanding
//  expire         : high during the TIMEOUT_CYC-th consecutive cycle of run
module mem_watchdog #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic run,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!run) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + 1'b1;
    end
  end

  // Count is 0 in the first request cycle, so LAST marks cycle TIMEOUT_CYC.
  assign expire = run && (count == LAST);

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage, downstream of execute.
// Accepts one executed instruction per in_valid/in_ready handshake, performs
// word LW/SW over a req/ack data-memory bus, passes ALU/JAL results through,
// and presents a writeback record on out_* with an out_valid/out_ready handshake.
//  clock, reset_n          : clock, asynchronous active-low reset
//  in_*                    : execute result (op, funct3, rd, rd_d, addr, memw_d, pc)
//  dmem_*                  : data-memory bus (req/we/addr/wdata out, ack/rdata in)
//  out_*                   : writeback record (we, rd, rd_d, pc)
//  mem_err                 : sticky ack-timeout flag
// Build option: define MEM_TIMEOUT_EN to abort requests not acked within
// TIMEOUT_CYC cycles; otherwise MEM waits indefinitely and mem_err is 0.
module memory_access
  import core_pkg::*;
#(
  parameter int XLEN        = CORE_XLEN,
  parameter int RIDX_W      = CORE_RIDX_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_op,
  input  logic [2:0]        in_funct3,
  input  logic [RIDX_W-1:0] in_rd,
  input  logic [XLEN-1:0]   in_rd_d,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_memw_d,
  input  logic [XLEN-1:0]   in_pc,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_we,
  output logic [RIDX_W-1:0] out_rd,
  output logic [XLEN-1:0]   out_rd_d,
  output logic [XLEN-1:0]   out_pc,
  output logic              mem_err
);

  mem_state_t state;
  wb_elements wb;
  logic       mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;

  logic in_is_load;
  logic in_is_store;
  logic accept;
  logic timeout;

  assign in_is_load  = (in_op == OP_LOAD)  && (in_funct3 == F3_WORD);
  assign in_is_store = (in_op == OP_STORE) && (in_funct3 == F3_WORD);

  // HOLD can take a new record in the same cycle its current one drains.
  assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept   = in_valid && in_ready;

`ifdef MEM_TIMEOUT_EN
  logic err_q;

  mem_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clock  (clock),
    .reset_n(reset_n),
    .run    (state == MEM),
    .expire (timeout)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if ((state == MEM) && timeout && !dmem_ack) begin
      err_q <= 1'b1;
    end
  end

  assign mem_err = err_q;
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wb        <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            wb.we     <= wb_write_en(in_op, in_funct3, in_rd);
            wb.rd     <= in_rd;
            wb.rd_d   <= in_rd_d;
            wb.pc     <= in_pc;
            mem_we    <= in_is_store;
            mem_addr  <= in_addr;
            mem_wdata <= in_memw_d;
            state     <= (in_is_load || in_is_store) ? MEM : HOLD;
          end else if ((state == HOLD) && out_ready) begin
            state <= IDLE;
          end
        end
        MEM: begin
          // An ack on the watchdog's limit cycle completes normally.
          if (dmem_ack) begin
            if (!mem_we) wb.rd_d <= dmem_rdata;
            state <= HOLD;
          end else if (timeout) begin
            wb.we <= 1'b0;
            state <= HOLD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dmem_req   = (state == MEM);
  assign dmem_we    = dmem_req && mem_we;
  assign dmem_addr  = mem_addr;
  assign dmem_wdata = mem_wdata;

  assign out_valid = (state == HOLD);
  assign out_we    = wb.we;
  assign out_rd    = wb.rd;
  assign out_rd_d  = wb.rd_d;
  assign out_pc    = wb.pc;

endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for memory_access.
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_memory_access;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_op = '0;
  logic [2:0]  in_funct3 = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_rd_d = '0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_memw_d = '0;
  logic [31:0] in_pc = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_we;
  logic [4:0]  out_rd;
  logic [31:0] out_rd_d;
  logic [31:0] out_pc;
  logic        mem_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  memory_access #(.XLEN(32), .RIDX_W(5), .TIMEOUT_CYC(16)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_funct3 (in_funct3),
    .in_rd     (in_rd),
    .in_rd_d   (in_rd_d),
    .in_addr   (in_addr),
    .in_memw_d (in_memw_d),
    .in_pc     (in_pc),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_ack  (dmem_ack),
    .dmem_rdata(dmem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_we    (out_we),
    .out_rd    (out_rd),
    .out_rd_d  (out_rd_d),
    .out_pc    (out_pc),
    .mem_err   (mem_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Presents one record for a single cycle; returns 1 ns after the accept edge.
  task automatic send(input logic [7:0] op, input logic [2:0] f3, input logic [4:0] rd,
                      input logic [31:0] rd_d, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] pc);
    in_op = op; in_funct3 = f3; in_rd = rd; in_rd_d = rd_d;
    in_addr = addr; in_memw_d = wd; in_pc = pc; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  // Counts request cycles until ack/timeout, bounded.
  task automatic count_req(output int cycles);
    cycles = 0;
    while (dmem_req && cycles < 40) begin
      cycles++;
      step();
    end
  endtask

  typedef struct {
    logic [7:0] op;
    logic [2:0] f3;
    logic [4:0] rd;
    logic       we;
  } vec_t;

  vec_t vecs[6];
  int   cyc;

  initial begin
    vecs[0] = '{8'h13, 3'h0, 5'd4,  1'b1};  // ADDI
    vecs[1] = '{8'h6f, 3'h0, 5'd1,  1'b1};  // JAL
    vecs[2] = '{8'h33, 3'h0, 5'd0,  1'b0};  // ADD to x0: write suppressed
    vecs[3] = '{8'h63, 3'h1, 5'd6,  1'b0};  // branch
    vecs[4] = '{8'h03, 3'h0, 5'd8,  1'b0};  // LB: unknown funct3, no memory access
    vecs[5] = '{8'h7f, 3'h2, 5'd9,  1'b0};  // unknown opcode

    // Reset state
    #2;
    check("rst_req", dmem_req, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_we", out_we, 0);
    check("rst_out_rd_d", out_rd_d, 0);
    check("rst_mem_err", mem_err, 0);
    step();
    reset_n = 1'b1;
    step();
    check("idle_in_ready", in_ready, 1);

    // 1. ADD passes through in one cycle
    out_ready = 1'b1;
    send(8'h33, 3'h0, 5'd5, 32'h1234, 32'h0, 32'h0, 32'h104);
    check("add_valid", out_valid, 1);
    check("add_we", out_we, 1);
    check("add_rd", out_rd, 5);
    check("add_rd_d", out_rd_d, 32'h1234);
    check("add_pc", out_pc, 32'h104);
    check("add_no_req", dmem_req, 0);
    step();
    check("add_drained", out_valid, 0);

    // 2. LW with ack in the third request cycle
    send(8'h03, 3'h2, 5'd7, 32'h0, 32'h40, 32'h0, 32'h200);
    check("lw_in_ready_mem", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      check("lw_req", dmem_req, 1);
      check("lw_addr", dmem_addr, 32'h40);
      check("lw_we", dmem_we, 0);
      check("lw_not_valid", out_valid, 0);
      if (i == 2) begin
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
      end
      step();
    end
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    check("lw_req_drop", dmem_req, 0);
    check("lw_valid", out_valid, 1);
    check("lw_rd_d", out_rd_d, 32'hDEADBEEF);
    check("lw_we_out", out_we, 1);
    check("lw_rd", out_rd, 7);
    step();

    // 3. SW, ack in the first request cycle (2-cycle latency)
    send(8'h23, 3'h2, 5'd3, 32'h0, 32'h10, 32'h55, 32'h300);
    check("sw_req", dmem_req, 1);
    check("sw_dmem_we", dmem_we, 1);
    check("sw_addr", dmem_addr, 32'h10);
    check("sw_wdata", dmem_wdata, 32'h55);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    check("sw_valid", out_valid, 1);
    check("sw_out_we", out_we, 0);
    check("sw_pc", out_pc, 32'h300);
    step();

    // 4. Backpressure for 4 cycles, then back-to-back accept
    out_ready = 1'b0;
    send(8'h13, 3'h0, 5'd9, 32'hAAAA, 32'h0, 32'h0, 32'h400);
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_rd_d", out_rd_d, 32'hAAAA);
      check("bp_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", in_ready, 1);
    send(8'h6f, 3'h0, 5'd1, 32'h100, 32'h0, 32'h0, 32'h500);
    check("b2b_valid", out_valid, 1);
    check("b2b_rd", out_rd, 1);
    check("b2b_rd_d", out_rd_d, 32'h100);
    check("b2b_pc", out_pc, 32'h500);
    step();
    check("b2b_drained", out_valid, 0);

    // Write-enable decode table (non-memory ops)
    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].f3, vecs[i].rd, 32'h77 + i, 32'h80, 32'h0, 32'h600);
      check("tbl_no_req", dmem_req, 0);
      check("tbl_valid", out_valid, 1);
      check("tbl_we", out_we, vecs[i].we);
      check("tbl_rd_d", out_rd_d, 32'h77 + i);
      step();
    end

    // 5. Reset during MEM
    send(8'h03, 3'h2, 5'd2, 32'h0, 32'h44, 32'h0, 32'h700);
    check("rstm_req", dmem_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstm_req_drop", dmem_req, 0);
    check("rstm_valid", out_valid, 0);
    step();
    reset_n = 1'b1;
    step();
    check("rstm_idle", in_ready, 1);
    check("rstm_no_req", dmem_req, 0);
    check("rstm_no_valid", out_valid, 0);

    // 6. Watchdog
`ifdef MEM_TIMEOUT_EN
    send(8'h03, 3'h2, 5'd11, 32'h0, 32'h48, 32'h0, 32'h800);
    count_req(cyc);
    check("to_req_cycles", cyc, 16);
    check("to_mem_err", mem_err, 1);
    check("to_valid", out_valid, 1);
    check("to_we", out_we, 0);
    step();
    do_reset();
    check("to_err_cleared", mem_err, 0);
    // Ack on the limit cycle wins
    send(8'h03, 3'h2, 5'd12, 32'h0, 32'h4c, 32'h0, 32'h900);
    for (int i = 0; i < 15; i++) step();
    check("lim_req", dmem_req, 1);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFE0001;
    step();
    dmem_ack = 1'b0;
    check("lim_valid", out_valid, 1);
    check("lim_we", out_we, 1);
    check("lim_rd_d", out_rd_d, 32'hCAFE0001);
    check("lim_mem_err", mem_err, 0);
    step();
`else
    send(8'h03, 3'h2, 5'd11, 32'h0, 32'h48, 32'h0, 32'h800);
    for (int i = 0; i < 20; i++) step();
    check("nto_req_held", dmem_req, 1);
    check("nto_mem_err", mem_err, 0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h0BADF00D;
    step();
    dmem_ack = 1'b0;
    check("nto_valid", out_valid, 1);
    check("nto_rd_d", out_rd_d, 32'h0BADF00D);
    step();
    do_reset();
    count_req(cyc);
    check("nto_idle_no_req", cyc, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
